// File: rtl/s420_pattern_loader.sv
// Serial coefficient loader and run sequencer for the s420 counter stage.
// Patterns shift in MSB first, load into C on LD, then START runs P_0 for LEN cycles.
module s420_pattern_loader (
  input  logic        CK,
  input  logic        RSTN,
  input  logic        SI,
  input  logic        SE,
  input  logic        LD,
  input  logic        START,
  input  logic [7:0]  LEN,
  output logic [16:0] C,
  output logic        P_0,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  // state | meaning
  // IDLE  | waiting for START; LD may be accepted
  // RUN   | counter stage enabled (P_0 high), run counter counting down
  // FIN   | one-cycle end-of-run, DONE high
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [4:0] BCNT_FULL = 5'd17;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [16:0] r_sr;
  logic [16:0] r_c;
  logic [4:0]  r_bcnt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        r_p0;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        w_ld_ok;
  logic        w_start_ok;
  logic        w_viol;

  assign w_ld_ok    = LD && (r_bcnt == BCNT_FULL) && (r_state == IDLE);
  assign w_start_ok = START && (r_state == IDLE);
  assign w_viol     = (LD && !w_ld_ok) || (START && !w_start_ok);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (START) begin
          if (LEN != 8'd0) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = LEN - 8'd1;
          end else begin
            w_state_nxt = FIN;
          end
        end
      end
      RUN: begin
        if (r_cnt == 8'd0) w_state_nxt = FIN;
        else               w_cnt_nxt   = r_cnt - 8'd1;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_p0    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_p0    <= (w_state_nxt == RUN);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == FIN);
    end
  end

  // LD (accepted or not) takes priority over SE, so a shift never races a load.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_sr   <= 17'd0;
      r_bcnt <= 5'd0;
      r_c    <= 17'd0;
    end else if (LD) begin
      if (w_ld_ok) begin
        r_c    <= r_sr;
        r_bcnt <= 5'd0;
      end
    end else if (SE) begin
      r_sr <= {r_sr[15:0], SI};
      if (r_bcnt != BCNT_FULL) r_bcnt <= r_bcnt + 5'd1;
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)           r_err <= 1'b0;
    else if (w_viol)     r_err <= 1'b1;
    else if (w_start_ok) r_err <= 1'b0;
  end

  assign C    = r_c;
  assign P_0  = r_p0;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ERR  = r_err;

endmodule

// File: tb/tb_s420_pattern_loader.sv
// Directed bench for s420_pattern_loader: load, run, violations, boundaries, reset.
module tb_s420_pattern_loader;

  logic        CK = 1'b0;
  logic        RSTN = 1'b0;
  logic        SI = 1'b0;
  logic        SE = 1'b0;
  logic        LD = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  LEN = 8'd0;
  logic [16:0] C;
  logic        P_0;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int checks = 0;
  int failures = 0;

  s420_pattern_loader dut (
    .CK(CK), .RSTN(RSTN), .SI(SI), .SE(SE), .LD(LD), .START(START), .LEN(LEN),
    .C(C), .P_0(P_0), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic shift_bits(input logic [16:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SE = 1'b1;
      SI = val[i];
      tick();
    end
    SE = 1'b0;
    SI = 1'b0;
  endtask

  task automatic do_ld();
    LD = 1'b1;
    tick();
    LD = 1'b0;
  endtask

  // Issues START and counts P_0/BUSY/DONE samples until the cycle after DONE.
  task automatic run_measure(input logic [7:0] len, output int p, output int b,
                             output int d, output bit tmo);
    p = 0; b = 0; d = 0; tmo = 1'b1;
    START = 1'b1;
    LEN = len;
    tick();
    START = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (P_0)  p++;
      if (BUSY) b++;
      if (DONE) d++;
      if (DONE) begin
        tmo = 1'b0;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (C !== 17'd0)  begin failures++; $display("FAIL reset_c: got %0h expected 0", C); end
    checks++; if (P_0 !== 1'b0) begin failures++; $display("FAIL reset_p0: got %0b expected 0", P_0); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", DONE); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b expected 0", ERR); end
    @(negedge CK);
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_basic_load_run();
    int p, b, d;
    bit tmo;
    shift_bits(17'h10005, 17);
    do_ld();
    checks++; if (C !== 17'h10005) begin failures++; $display("FAIL basic_c: got %0h expected 10005", C); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL basic_err: got %0b expected 0", ERR); end
    run_measure(8'd3, p, b, d, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL basic_timeout: got %0b expected 0", tmo); end
    checks++; if (p !== 3) begin failures++; $display("FAIL basic_p0_cycles: got %0d expected 3", p); end
    checks++; if (b !== 4) begin failures++; $display("FAIL basic_busy_cycles: got %0d expected 4", b); end
    checks++; if (d !== 1) begin failures++; $display("FAIL basic_done_cycles: got %0d expected 1", d); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %0b expected 0", BUSY); end
  endtask

  task automatic test_short_load();
    int p, b, d;
    bit tmo;
    shift_bits(17'h003FF, 10);
    do_ld();
    checks++; if (C !== 17'h10005) begin failures++; $display("FAIL short_c: got %0h expected 10005", C); end
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL short_err_set: got %0b expected 1", ERR); end
    run_measure(8'd1, p, b, d, tmo);
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL short_err_clr: got %0b expected 0", ERR); end
    checks++; if (p !== 1) begin failures++; $display("FAIL short_p0_cycles: got %0d expected 1", p); end
    checks++; if (d !== 1 || tmo) begin failures++; $display("FAIL short_done: got %0d expected 1", d); end
  endtask

  task automatic test_run_violations();
    logic [16:0] w;
    int p, d;
    w = 17'h1B3C5;
    p = 0; d = 0;
    START = 1'b1;
    LEN = 8'd5;
    tick();
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (P_0)  p++;
      if (DONE) d++;
      START = (cyc == 0);
      LD    = (cyc == 2);
      SE    = (cyc >= 3) && (cyc < 20);
      SI    = ((cyc >= 3) && (cyc < 20)) ? w[19 - cyc] : 1'b0;
      tick();
    end
    START = 1'b0; LD = 1'b0; SE = 1'b0; SI = 1'b0;
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL viol_err: got %0b expected 1", ERR); end
    checks++; if (p !== 5) begin failures++; $display("FAIL viol_p0_cycles: got %0d expected 5", p); end
    checks++; if (d !== 1) begin failures++; $display("FAIL viol_done_cycles: got %0d expected 1", d); end
    checks++; if (C !== 17'h10005) begin failures++; $display("FAIL viol_c_held: got %0h expected 10005", C); end
    do_ld();
    checks++; if (C !== 17'h1B3C5) begin failures++; $display("FAIL viol_prefetch_ld: got %0h expected 1b3c5", C); end
  endtask

  task automatic test_boundaries();
    int p, b, d;
    bit tmo;
    run_measure(8'd0, p, b, d, tmo);
    checks++; if (p !== 0) begin failures++; $display("FAIL len0_p0: got %0d expected 0", p); end
    checks++; if (b !== 1) begin failures++; $display("FAIL len0_busy: got %0d expected 1", b); end
    checks++; if (d !== 1 || tmo) begin failures++; $display("FAIL len0_done: got %0d expected 1", d); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL len0_err_clr: got %0b expected 0", ERR); end
    run_measure(8'd255, p, b, d, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL len255_timeout: got %0b expected 0", tmo); end
    checks++; if (p !== 255) begin failures++; $display("FAIL len255_p0: got %0d expected 255", p); end
    checks++; if (b !== 256) begin failures++; $display("FAIL len255_busy: got %0d expected 256", b); end
  endtask

  task automatic test_simultaneous();
    bit seen_done;
    shift_bits(17'h15555, 17);
    SE = 1'b1; SI = 1'b1; LD = 1'b1;
    tick();
    SE = 1'b0; SI = 1'b0; LD = 1'b0;
    checks++; if (C !== 17'h15555) begin failures++; $display("FAIL se_ld_c: got %0h expected 15555", C); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL se_ld_err: got %0b expected 0", ERR); end
    do_ld();
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL se_ld_bcnt_clr: got %0b expected 1", ERR); end
    shift_bits(17'h0F0F1, 17);
    START = 1'b1; LEN = 8'd2; LD = 1'b1;
    tick();
    START = 1'b0; LD = 1'b0;
    checks++; if (C !== 17'h0F0F1 || P_0 !== 1'b1) begin
      failures++; $display("FAIL start_ld_c: got c=%0h p0=%0b expected c=f0f1 p0=1", C, P_0);
    end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL start_ld_err: got %0b expected 0", ERR); end
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen_done; cyc++) begin
      if (DONE) seen_done = 1'b1;
      tick();
    end
    checks++; if (seen_done !== 1'b1) begin failures++; $display("FAIL start_ld_done: got %0b expected 1", seen_done); end
  endtask

  task automatic test_reset_mid_run();
    int d, p;
    START = 1'b1; LEN = 8'd20;
    tick();
    START = 1'b0;
    tick(); tick();
    #2;
    RSTN = 1'b0;
    #1;
    checks++; if (P_0 !== 1'b0) begin failures++; $display("FAIL rst_mid_p0: got %0b expected 0", P_0); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %0b expected 0", BUSY); end
    checks++; if (C !== 17'd0) begin failures++; $display("FAIL rst_mid_c: got %0h expected 0", C); end
    @(negedge CK);
    RSTN = 1'b1;
    d = 0; p = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (DONE) d++;
      if (P_0)  p++;
    end
    checks++; if (d !== 0) begin failures++; $display("FAIL rst_mid_no_done: got %0d expected 0", d); end
    checks++; if (p !== 0) begin failures++; $display("FAIL rst_mid_no_p0: got %0d expected 0", p); end
  endtask

  initial begin
    test_reset();
    test_basic_load_run();
    test_short_load();
    test_run_violations();
    test_boundaries();
    test_simultaneous();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s420_pattern_loader.md
S420_PATTERN_LOADER -- requirements
Module: s420_pattern_loader

Interface
REQ-001 SHALL have `CK  in  1`: the single clock; all state updates on its rising edge.
REQ-002 SHALL have `RSTN  in  1`: reset, asynchronous, active-low.
REQ-003 SHALL have `SI  in  1`: serial pattern data, MSB first.
REQ-004 SHALL have `SE  in  1`: shift enable; one SI bit is taken per cycle while high.
REQ-005 SHALL have `LD  in  1`: load strobe; transfers the assembled shift word to C.
REQ-006 SHALL have `START  in  1`: run request.
REQ-007 SHALL have `LEN  in  8`: run length in cycles, sampled on an accepted START.
REQ-008 SHALL have `C  out  17`: coefficient word driving counter-stage inputs C_16..C_0 (C[i] drives C_i).
REQ-009 SHALL have `P_0  out  1`: count enable driving the counter stage.
REQ-010 SHALL have `BUSY  out  1`: high whenever state is not IDLE.
REQ-011 SHALL have `DONE  out  1`: one-cycle end-of-run pulse.
REQ-012 SHALL have `ERR  out  1`: sticky protocol-violation flag.

Function
REQ-013 SHALL hold a 17-bit shift register SR and a 5-bit shift count BCNT.
- On an SE cycle: SR <= {SR[15:0], SI}.
- BCNT increments and saturates at 17.
REQ-014 SHALL accept LD only when BCNT==17 and state==IDLE.
- Accepted LD: C <= SR and BCNT <= 0 on the same edge.
REQ-015 SHALL, on LD with BCNT<17 or state!=IDLE, leave C and BCNT unchanged and set ERR.
REQ-016 SHALL, when SE and LD are both high, suppress that cycle's shift. LD then acts on the pre-edge SR and BCNT.
REQ-017 SHALL allow shifting (SE) in any state, so the next pattern can be prefetched during a run.
REQ-018 SHALL implement FSM states IDLE, RUN and FIN, with these transitions:
- IDLE -> RUN on START with LEN!=0.
- IDLE -> FIN on START with LEN==0.
- RUN -> FIN when the run counter is 0.
- FIN -> IDLE unconditionally after one cycle.
REQ-019 SHALL register all outputs: P_0 = (state==RUN), DONE = (state==FIN).
REQ-020 SHALL, on START accepted at edge k with LEN=N>0:
- load the 8-bit run counter with N-1;
- hold P_0 high for exactly N cycles, after edges k..k+N-1;
- decrement the counter on each RUN edge;
- pulse DONE for one cycle after edge k+N.
REQ-021 SHALL, on START with LEN==0, pulse DONE one cycle after the START edge with no P_0 assertion.
REQ-022 SHALL ignore START in RUN or FIN and set ERR.
REQ-023 SHALL, on START and an accepted LD in the same IDLE cycle, perform both on one edge, so the run uses the new C.
REQ-024 SHALL clear ERR only on reset or on an accepted START; an accepted START clears ERR only if no violation occurs in that cycle.
REQ-025 SHALL keep C constant at all times except on an accepted LD.

Reset
REQ-026 SHALL, while RSTN==0, immediately force the following regardless of CK:
- state=IDLE;
- SR=0, BCNT=0, run counter=0;
- C=0;
- P_0=0, BUSY=0, DONE=0, ERR=0.
REQ-027 SHALL, on reset mid-run, drop P_0 asynchronously and produce no DONE pulse.
REQ-028 SHALL resume operation on the first rising CK edge after RSTN returns high.

Verification
REQ-029 SHALL cover a basic load and run:
- 17 SE cycles shifting 1_0000_0000_0000_0101, then LD -> C=0x10005.
- START with LEN=3 -> P_0 high 3 cycles, then DONE for 1 cycle, BUSY high 4 cycles.
REQ-030 SHALL cover a short load: LD after 10 shifts -> C unchanged, ERR=1. A later START with LEN=1 -> ERR=0, P_0 high 1 cycle.
REQ-031 SHALL cover violations during a run:
- START issued during a LEN=5 run -> ERR=1, run still exactly 5 P_0 cycles.
- LD during that run -> C unchanged.
- 17 shifts during that run followed by LD in IDLE -> new C loaded.
REQ-032 SHALL cover boundary cases:
- START with LEN=0 -> DONE next cycle, P_0 never high.
- START with LEN=255 -> P_0 high exactly 255 cycles.
REQ-033 SHALL cover simultaneous events:
- SE+LD in the same cycle with BCNT=17 -> C = pre-edge SR, BCNT=0.
- START+LD in the same cycle -> first P_0 cycle already sees the new C.
REQ-034 SHALL cover reset mid-operation:
- RSTN low mid-run, between CK edges -> P_0, BUSY and C go to 0 without waiting for an edge; no DONE after release.
